uart_receiver: RTL and testbench

Serial-to-parallel UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It is the receive-side counterpart of the UART transmitter and shares its baud-rate generator, which supplies a 16x oversample tick instead of the 1x tick. The block synchronizes the asynchronous line, validates the start bit, samples each bit at its centre and presents the byte through a valid/read handshake. It reports framing errors and overrun.

---
 rtl/uart_receiver_if.sv | 21 ++
 rtl/uart_receiver.sv | 143 ++++++++++++++
 tb/tb_uart_receiver.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Byte handshake between uart_receiver and its consumer.
interface uart_receiver_if;
  logic [7:0] data_out;
  logic       valid;
  logic       framing_err;
  logic       overrun;
  logic       busy;
  logic       rd_en;

  modport master (
    output data_out, valid, framing_err,
    output overrun, busy,
    input  rd_en
  );

  modport slave (
    input  data_out, valid, framing_err,
    input  overrun, busy,
    output rd_en
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver on a 16x oversample tick.
// UART_RX_MAJORITY_EN: 2-of-3 majority sampling.
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic os_tick,
  uart_receiver_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] S_START =
    TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] S_BIT =
    TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [TW-1:0]          tick_cnt;
  logic [TW-1:0]          s_pt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift_reg;
  logic                   s_hit;
  logic                   sample;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s  = sync_q[SYNC_STAGES-1];
  assign s_pt  = (state == START) ? S_START : S_BIT;
  assign s_hit = os_tick && (tick_cnt == s_pt);

`ifdef UART_RX_MAJORITY_EN
  logic maj_a;
  logic maj_b;

  // Earlier two votes are captured on the ticks just before S.
  always_ff @(posedge clk) begin
    if (rst) begin
      maj_a <= 1'b1;
      maj_b <= 1'b1;
    end else if (os_tick) begin
      if (tick_cnt == s_pt - TW'(2)) maj_a <= rx_s;
      if (tick_cnt == s_pt - TW'(1)) maj_b <= rx_s;
    end
  end

  assign sample = (maj_a & maj_b) |
                  (maj_a & rx_s)  |
                  (maj_b & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      tick_cnt        <= '0;
      bit_idx         <= '0;
      shift_reg       <= '0;
      bus.data_out    <= '0;
      bus.valid       <= 1'b0;
      bus.framing_err <= 1'b0;
      bus.overrun     <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.framing_err <= 1'b0;
      if (bus.rd_en && bus.valid) begin
        bus.valid   <= 1'b0;
        bus.overrun <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
            bus.busy <= 1'b1;
          end
        end
        START: begin
          if (s_hit) begin
            tick_cnt <= '0;
            if (!sample) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else if (os_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (s_hit) begin
            tick_cnt           <= '0;
            shift_reg[bit_idx] <= sample;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else if (os_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (s_hit) begin
            tick_cnt <= '0;
            if (sample) begin
              state        <= IDLE;
              bus.busy     <= 1'b0;
              bus.data_out <= shift_reg;
              bus.valid    <= 1'b1;
              // A concurrent read consumes the old byte: no overrun.
              if (bus.valid && !bus.rd_en)
                bus.overrun <= 1'b1;
            end else begin
              state           <= WAIT_HIGH;
              bus.framing_err <= 1'b1;
            end
          end else if (os_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bus.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver.
`timescale 1ns/1ps
module tb_uart_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic os_tick = 1'b0;

  uart_receiver_if bus ();

  uart_receiver #(
    .OVERSAMPLE(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .os_tick(os_tick),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int busy_rises = 0;
  logic busy_q = 1'b0;
  bit probe_en = 1'b0;

  always @(negedge clk) begin
    if (bus.framing_err === 1'b1) fe_cnt++;
    if (bus.busy === 1'b1 && !busy_q) busy_rises++;
    busy_q = bus.busy;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick(input bit rd);
    repeat (3) @(negedge clk);
    os_tick = 1'b1;
    bus.rd_en = rd;
    @(negedge clk);
    os_tick = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  // Frame bit i (0=start, 1..8=data, 9=stop), 16 ticks each.
  // glitch selects a frame bit whose centre tick is forced low.
  task automatic send_frame(input logic [7:0] d,
                            input bit stop,
                            input bit rd_s,
                            input int idle,
                            input int glitch);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int t = 0; t < 16; t++) begin
        rx = (glitch > 0 && i == glitch && t == 7)
             ? 1'b0 : bits[i];
        tick(i == 9 && t == 7 && rd_s);
        if (probe_en && i == 9 && t == 6)
          check("valid_before_s", bus.valid, 0);
        if (probe_en && i == 9 && t == 7) begin
          check("valid_at_s", bus.valid, 1);
          check("busy_at_s", bus.busy, 0);
          check("data_at_s", bus.data_out, 8'hA5);
        end
      end
    end
    rx = 1'b1;
    repeat (idle) tick(1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         rd_s;
    int         idle;
    bit         rd_after;
    bit         ev;
    logic [7:0] ed;
    bit         eo;
    int         efe;
  } vec_t;

  vec_t vecs[12];

  bit         mv;
  bit         mo;
  logic [7:0] md;
  logic [7:0] glitch_exp;

  initial begin
    vecs[0]  = '{8'hA5, 1, 0, 4, 0, 1, 8'hA5, 0, 0};
    vecs[1]  = '{8'h3C, 1, 0, 0, 1, 1, 8'h3C, 1, 0};
    vecs[2]  = '{8'h00, 1, 0, 2, 0, 1, 8'h00, 0, 0};
    vecs[3]  = '{8'hFF, 0, 0, 4, 1, 1, 8'h00, 0, 1};
    vecs[4]  = '{8'h81, 1, 1, 3, 0, 1, 8'h81, 0, 0};
    vecs[5]  = '{8'h7E, 1, 1, 3, 0, 1, 8'h7E, 0, 0};
    vecs[6]  = '{8'h11, 1, 0, 2, 0, 1, 8'h11, 1, 0};
    vecs[7]  = '{8'h22, 1, 1, 2, 1, 1, 8'h22, 0, 0};
    vecs[8]  = '{8'h11, 1, 0, 1, 0, 1, 8'h11, 0, 0};
    vecs[9]  = '{8'h22, 1, 0, 1, 1, 1, 8'h22, 1, 0};
    vecs[10] = '{8'h11, 1, 0, 1, 0, 1, 8'h11, 0, 0};
    vecs[11] = '{8'h22, 1, 1, 1, 1, 1, 8'h22, 0, 0};

    bus.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.valid, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_fe", bus.framing_err, 0);
    check("rst_ovr", bus.overrun, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    repeat (2) tick(1'b0);

    // Stop-bit centre timing on 0xA5.
    probe_en = 1'b1;
    send_frame(8'hA5, 1, 0, 4, 0);
    probe_en = 1'b0;

    // False start: 3 ticks low.
    busy_rises = 0;
    rx = 1'b0;
    repeat (3) tick(1'b0);
    rx = 1'b1;
    repeat (12) tick(1'b0);
    check("fs_busy_pulse", busy_rises, 1);
    check("fs_busy", bus.busy, 0);
    check("fs_valid", bus.valid, 1);
    check("fs_data", bus.data_out, 8'hA5);
    rd_pulse();
    check("rd_valid", bus.valid, 0);

    for (int k = 0; k < 12; k++) begin
      fe_cnt = 0;
      send_frame(vecs[k].data, vecs[k].stop,
                 vecs[k].rd_s, vecs[k].idle, 0);
      check($sformatf("v%0d_valid", k), bus.valid, vecs[k].ev);
      check($sformatf("v%0d_data", k), bus.data_out, vecs[k].ed);
      check($sformatf("v%0d_ovr", k), bus.overrun, vecs[k].eo);
      check($sformatf("v%0d_fe", k), fe_cnt, vecs[k].efe);
      if (vecs[k].rd_after) begin
        rd_pulse();
        check($sformatf("v%0d_rd_valid", k), bus.valid, 0);
        check($sformatf("v%0d_rd_ovr", k), bus.overrun, 0);
      end
    end

    // Break: bad stop then line low for 3 bit times.
    fe_cnt = 0;
    send_frame(8'h3C, 0, 0, 0, 0);
    rx = 1'b0;
    repeat (48) tick(1'b0);
    check("brk_fe_once", fe_cnt, 1);
    check("brk_valid", bus.valid, 0);
    check("brk_busy", bus.busy, 1);
    rx = 1'b1;
    repeat (4) tick(1'b0);
    check("brk_idle", bus.busy, 0);
    send_frame(8'h55, 1, 0, 2, 0);
    check("brk_data", bus.data_out, 8'h55);
    check("brk_valid2", bus.valid, 1);

    // Reset in the middle of data bit 4 of 0x5A.
    rx = 1'b0;
    repeat (16) tick(1'b0);
    for (int b = 0; b < 4; b++) begin
      rx = (8'h5A >> b) & 8'h01;
      repeat (16) tick(1'b0);
    end
    rx = 1'b1;
    repeat (8) tick(1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_valid", bus.valid, 0);
    check("mr_data", bus.data_out, 0);
    check("mr_ovr", bus.overrun, 0);
    check("mr_busy", bus.busy, 0);
    repeat (4) tick(1'b0);
    send_frame(8'hC3, 1, 0, 2, 0);
    check("mr_c3", bus.data_out, 8'hC3);

    // Centre glitch on data bit 2 of 0xFF.
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hFF;
`else
    glitch_exp = 8'hFB;
`endif
    send_frame(8'hFF, 1, 0, 2, 3);
    check("glitch_data", bus.data_out, glitch_exp);
    rd_pulse();

    mv = 0;
    mo = 0;
    md = glitch_exp;
    for (int k = 0; k < 25; k++) begin
      logic [7:0] d;
      bit st;
      bit rs;
      bit ra;
      int idl;
      d = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      rs = ($urandom_range(0, 3) == 0);
      ra = $urandom_range(0, 1);
      idl = st ? $urandom_range(0, 3) : $urandom_range(2, 4);
      fe_cnt = 0;
      send_frame(d, st, rs, idl, 0);
      if (st) begin
        if (rs) mo = 0;
        else if (mv) mo = 1;
        mv = 1;
        md = d;
      end else if (rs) begin
        mv = 0;
        mo = 0;
      end
      check($sformatf("r%0d_valid", k), bus.valid, mv);
      check($sformatf("r%0d_data", k), bus.data_out, md);
      check($sformatf("r%0d_ovr", k), bus.overrun, mo);
      check($sformatf("r%0d_fe", k), fe_cnt, st ? 0 : 1);
      if (ra) begin
        rd_pulse();
        mv = 0;
        mo = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
